// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory loads/stores over a req/ack handshake, load
// formatting, upstream hold while an access is in flight, and the MEM_WB bundle.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic [31:0] EX_MEM_alures,
    input  logic [31:0] EX_MEM_dout_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_regwrite,
    input  logic [4:0]  EX_MEM_loadcntrl,
    input  logic [2:0]  EX_MEM_storecntrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_hold,
    output logic        MEM_WB_regwrite,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] WB_res,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10} state_e;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;

    localparam int unsigned CW      = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 32'd0) ? TIMEOUT_CYCLES - 32'd1 : 32'd0;
    localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 32'd0);

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input size_e sz,
                                             input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_B:    res = {{24{sgn & b[7]}}, b};
            SZ_H:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_res_q, wb_res_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        lat_rw_q, lat_rw_d;
    logic        lat_ld_q, lat_ld_d;
    size_e       lat_sz_q, lat_sz_d;
    logic        lat_sgn_q, lat_sgn_d;
    logic [1:0]  lat_off_q, lat_off_d;

    size_e       size_s;
    logic        sign_s;
    logic        access_s;
    logic        is_store_s;
    logic        misalign_s;
    logic [1:0]  off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        hold_s;

    // Decode access size/sign (lowest one-hot bit wins, empty field means word) and lanes.
    always_comb begin
        size_s     = SZ_W;
        sign_s     = 1'b0;
        access_s   = EX_MEM_memread | EX_MEM_memwrite;
        is_store_s = EX_MEM_memwrite & ~EX_MEM_memread;
        off_s      = EX_MEM_alures[1:0];
        if (EX_MEM_memread) begin
            if (EX_MEM_loadcntrl[0]) begin
                size_s = SZ_B; sign_s = 1'b1;
            end else if (EX_MEM_loadcntrl[1]) begin
                size_s = SZ_H; sign_s = 1'b1;
            end else if (EX_MEM_loadcntrl[2]) begin
                size_s = SZ_W; sign_s = 1'b0;
            end else if (EX_MEM_loadcntrl[3]) begin
                size_s = SZ_B; sign_s = 1'b0;
            end else if (EX_MEM_loadcntrl[4]) begin
                size_s = SZ_H; sign_s = 1'b0;
            end else begin
                size_s = SZ_W; sign_s = 1'b0;
            end
        end else begin
            if (EX_MEM_storecntrl[0]) begin
                size_s = SZ_B;
            end else if (EX_MEM_storecntrl[1]) begin
                size_s = SZ_H;
            end else begin
                size_s = SZ_W;
            end
        end
        case (size_s)
            SZ_H: begin
                misalign_s = access_s & off_s[0];
                be_s       = off_s[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{EX_MEM_dout_rs2[15:0]}};
            end
            SZ_W: begin
                misalign_s = access_s & (off_s != 2'b00);
                be_s       = 4'b1111;
                wdata_s    = EX_MEM_dout_rs2;
            end
            default: begin
                misalign_s = 1'b0;
                be_s       = 4'b0001 << off_s;
                wdata_s    = {4{EX_MEM_dout_rs2[7:0]}};
            end
        endcase
        if (!is_store_s) begin
            be_s = 4'b1111;
        end else begin
            be_s = be_s;
        end
    end

    // Next-state, request and MEM_WB update logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_be_d     = dmem_be_q;
        dmem_wdata_d  = dmem_wdata_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_rd_d       = wb_rd_q;
        wb_res_d      = wb_res_q;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        fault_addr_d  = fault_addr_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        lat_rd_d      = lat_rd_q;
        lat_rw_d      = lat_rw_q;
        lat_ld_d      = lat_ld_q;
        lat_sz_d      = lat_sz_q;
        lat_sgn_d     = lat_sgn_q;
        lat_off_d     = lat_off_q;
        hold_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg) begin
                    state_d = IDLE;
                end else if (!access_s) begin
                    wb_rd_d       = EX_MEM_rd;
                    wb_regwrite_d = EX_MEM_regwrite;
                    wb_res_d      = EX_MEM_alures;
                end else if (misalign_s) begin
                    misalign_d    = 1'b1;
                    fault_addr_d  = EX_MEM_alures;
                    wb_regwrite_d = 1'b0;
                    wb_rd_d       = EX_MEM_rd;
                end else begin
                    hold_s       = 1'b1;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_store_s;
                    dmem_addr_d  = {EX_MEM_alures[31:2], 2'b00};
                    dmem_be_d    = be_s;
                    dmem_wdata_d = wdata_s;
                    lat_rd_d     = EX_MEM_rd;
                    lat_rw_d     = EX_MEM_regwrite;
                    lat_ld_d     = EX_MEM_memread;
                    lat_sz_d     = size_s;
                    lat_sgn_d    = sign_s;
                    lat_off_d    = off_s;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                hold_s = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (dmem_ack) begin
                    rdata_d    = dmem_rdata;
                    dmem_req_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = RESP;
                end else if (TO_EN && (cnt_q == TO_LAST_C)) begin
                    dmem_req_d   = 1'b0;
                    bus_err_d    = 1'b1;
                    fault_addr_d = EX_MEM_alures;
                    err_d        = 1'b1;
                    state_d      = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                // Upstream is released here; a debug freeze parks the result until dbg drops.
                if (dbg) begin
                    state_d = RESP;
                end else begin
                    wb_rd_d       = lat_rd_q;
                    wb_res_d      = (err_q || !lat_ld_q) ? 32'd0
                                  : fmt_load(rdata_q, lat_sz_q, lat_sgn_q, lat_off_q);
                    wb_regwrite_d = lat_rw_q & lat_ld_q & ~err_q;
                    err_d         = 1'b0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 32'd0;
            dmem_be_q     <= 4'd0;
            dmem_wdata_q  <= 32'd0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_res_q      <= 32'd0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            fault_addr_q  <= 32'd0;
            rdata_q       <= 32'd0;
            err_q         <= 1'b0;
            lat_rd_q      <= 5'd0;
            lat_rw_q      <= 1'b0;
            lat_ld_q      <= 1'b0;
            lat_sz_q      <= SZ_W;
            lat_sgn_q     <= 1'b0;
            lat_off_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_be_q     <= dmem_be_d;
            dmem_wdata_q  <= dmem_wdata_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_res_q      <= wb_res_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
            fault_addr_q  <= fault_addr_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            lat_rd_q      <= lat_rd_d;
            lat_rw_q      <= lat_rw_d;
            lat_ld_q      <= lat_ld_d;
            lat_sz_q      <= lat_sz_d;
            lat_sgn_q     <= lat_sgn_d;
            lat_off_q     <= lat_off_d;
        end
    end

    // Hold is gated by reset so every output reads 0 while Rst is low.
    assign mem_hold        = hold_s & Rst;
    assign dmem_req        = dmem_req_q;
    assign dmem_we         = dmem_we_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_be         = dmem_be_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign MEM_WB_regwrite = wb_regwrite_q;
    assign MEM_WB_rd       = wb_rd_q;
    assign WB_res          = wb_res_q;
    assign misalign        = misalign_q;
    assign bus_err         = bus_err_q;
    assign fault_addr      = fault_addr_q;

endmodule
